alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_pkg.sv | 43 ++++
 rtl/alu_regfile.sv | 50 +++++
 rtl/alu_exec_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for alu_exec_stage: ALU opcodes, instruction field layout and FSM encoding.
package alu_exec_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned PSR_W   = 5;

    // Instruction word: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned EXT_LSB = 4;
    localparam int unsigned RS_LSB  = 0;

    // Register-form opcodes are {4'h0, ext}; immediate forms are {op, 4'h0}
    localparam logic [OPC_W-1:0] OPC_AND = 8'h01;
    localparam logic [OPC_W-1:0] OPC_OR  = 8'h02;
    localparam logic [OPC_W-1:0] OPC_XOR = 8'h03;
    localparam logic [OPC_W-1:0] OPC_ADD = 8'h05;
    localparam logic [OPC_W-1:0] OPC_SUB = 8'h09;
    localparam logic [OPC_W-1:0] OPC_CMP = 8'h0B;

    localparam logic [FIELD_W-1:0] OPC_ANDI_OP = 4'h1;
    localparam logic [FIELD_W-1:0] OPC_ORI_OP  = 4'h2;
    localparam logic [FIELD_W-1:0] OPC_XORI_OP = 4'h3;
    localparam logic [FIELD_W-1:0] OPC_ADDI_OP = 4'h5;
    localparam logic [FIELD_W-1:0] OPC_SUBI_OP = 4'h9;
    localparam logic [FIELD_W-1:0] OPC_CMPI_OP = 4'hB;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOper = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } state_e;

    function automatic logic is_compare(input logic [FIELD_W-1:0] op,
                                        input logic [OPC_W-1:0]   opcode);
        return (op == '0) ? (opcode == OPC_CMP) : (op == OPC_CMPI_OP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational operand reads, one debug read, one synchronous write,
// asynchronous clear. ALU_EXEC_R0_ZERO_EN makes R0 read as zero and drops writes to it.
module alu_regfile #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [IDX_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic                        wr_ok;

    function automatic logic [WIDTH-1:0] read_reg(input logic [IDX_W-1:0] addr);
`ifdef ALU_EXEC_R0_ZERO_EN
        return (addr == '0) ? '0 : regs[addr];
`else
        return regs[addr];
`endif
    endfunction

`ifdef ALU_EXEC_R0_ZERO_EN
    assign wr_ok = wr_en && (wr_addr != '0);
`else
    assign wr_ok = wr_en;
`endif

    assign rd_data_a = read_reg(rd_addr_a);
    assign rd_data_b = read_reg(rd_addr_b);
    assign dbg_data  = read_reg(dbg_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Four-state execute stage driving an external ALU: IDLE -> OPER -> EXEC -> WB.
// Optional ALU_EXEC_R0_ZERO_EN (in alu_regfile) hard-wires R0 to zero.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned NREGS    = 16,
    parameter int unsigned RESULT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [RESULT_W-1:0] alu_A,
    output logic [RESULT_W-1:0] alu_B,
    output logic [OPC_W-1:0]    alu_Opcode,
    input  logic [RESULT_W-1:0] alu_C,
    input  logic                alu_Carry,
    input  logic                alu_Flag,
    input  logic                alu_Low,
    input  logic                alu_Negative,
    input  logic                alu_Zero,
    output logic [PSR_W-1:0]    psr,
    output logic                done,
    input  logic [FIELD_W-1:0]  dbg_addr,
    output logic [RESULT_W-1:0] dbg_data
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_e              state_q;
    logic [RESULT_W-1:0] opa_q, opb_q, res_c_q;
    logic [OPC_W-1:0]    opc_q;
    logic [IDX_W-1:0]    dest_q;
    logic                cmp_q;
    logic [PSR_W-1:0]    res_flags_q;

    logic [FIELD_W-1:0]  dec_op, dec_ext;
    logic [IDX_W-1:0]    dec_rd, dec_rs;
    logic [RESULT_W-1:0] rdata_a, rdata_b, imm_ext, dec_b;
    logic [OPC_W-1:0]    dec_opc;
    logic                reg_form, dec_cmp, wr_en;

    assign dec_op   = in_instr[OP_LSB +: FIELD_W];
    assign dec_ext  = in_instr[EXT_LSB +: FIELD_W];
    assign dec_rd   = in_instr[RD_LSB +: IDX_W];
    assign dec_rs   = in_instr[RS_LSB +: IDX_W];
    assign imm_ext  = {{(RESULT_W - IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    assign reg_form = (dec_op == '0);
    assign dec_opc  = reg_form ? {dec_op, dec_ext} : {dec_op, {FIELD_W{1'b0}}};
    assign dec_b    = reg_form ? rdata_b : imm_ext;
    assign dec_cmp  = is_compare(dec_op, dec_opc);

    assign in_ready = (state_q == StIdle);
    // Compares only touch psr; the result register is never written back
    assign wr_en    = (state_q == StWb) && !cmp_q;

    alu_regfile #(
        .NREGS (NREGS),
        .WIDTH (RESULT_W),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (dec_rd),
        .rd_data_a (rdata_a),
        .rd_addr_b (dec_rs),
        .rd_data_b (rdata_b),
        .dbg_addr  (dbg_addr[IDX_W-1:0]),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (dest_q),
        .wr_data   (res_c_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= '0;
            dest_q      <= '0;
            cmp_q       <= 1'b0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_Opcode  <= '0;
            psr         <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        opa_q   <= rdata_a;
                        opb_q   <= dec_b;
                        opc_q   <= dec_opc;
                        dest_q  <= dec_rd;
                        cmp_q   <= dec_cmp;
                        state_q <= StOper;
                    end
                end
                StOper: begin
                    alu_A      <= opa_q;
                    alu_B      <= opb_q;
                    alu_Opcode <= opc_q;
                    state_q    <= StExec;
                end
                StExec: begin
                    res_c_q     <= alu_C;
                    res_flags_q <= {alu_Carry, alu_Flag, alu_Low, alu_Negative, alu_Zero};
                    state_q     <= StWb;
                end
                StWb: begin
                    psr     <= res_flags_q;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
